// File: rtl/processor_multicycle_controller.sv
// -----------------------------------------------------------------------------
// processor_multicycle_controller
//
// Control FSM for a multi-cycle MIPS-subset datapath (shared memory, single
// ALU, IR/PC registers). Each state drives the datapath muxes and enables for
// one cycle; memory states stall on mem_ready. Supported opcodes: R-type
// (000000), LW (100011), SW (101011), BEQ (000100), J (000010), ADDI (001000).
// Any other opcode is flagged in DECODE and the FSM returns to FETCH.
//
// Optional feature macro: INSTR_COUNT_EN
//   defined   -> instr_count counts instr_done cycles (wraps, cleared by rst)
//   undefined -> instr_count tied to 0, no counter register
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset; forces all outputs to 0
//   opcode[5:0]   in   IR[31:26], sampled in DECODE and MEM_ADDR only
//   mem_ready     in   memory completes the current access this cycle
//   pc_write      out  unconditional PC load
//   pc_write_cond out  PC load if ALU zero
//   iord          out  memory address mux (0=PC, 1=ALUOut)
//   mem_read      out  memory read request
//   mem_write     out  memory write request
//   ir_write      out  IR load
//   mem_to_reg    out  register write data (0=ALUOut, 1=MDR)
//   reg_dst       out  destination register (0=rt, 1=rd)
//   reg_write     out  register file write enable
//   alu_src_a     out  0=PC, 1=reg A
//   alu_src_b[1:0] out 00=B, 01=4, 10=sext imm, 11=sext imm<<2
//   alu_op[1:0]   out  00=add, 01=sub, 10=funct-decoded
//   pc_source[1:0] out 00=ALU result, 01=ALUOut, 10=jump target
//   state[3:0]    out  current state encoding
//   instr_done    out  pulse in the final cycle of each instruction
//   illegal_op    out  pulse in DECODE on an unknown opcode
//   instr_count   out  retired instruction count
// -----------------------------------------------------------------------------
module processor_multicycle_controller #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           opcode,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic                 iord,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 mem_to_reg,
    output logic                 reg_dst,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [1:0]           pc_source,
    output logic [3:0]           state,
    output logic                 instr_done,
    output logic                 illegal_op,
    output logic [CNT_WIDTH-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t state_q, state_d;

    // Ungated decode of the current state; reset masking is applied below.
    logic       pc_write_raw, pc_write_cond_raw, iord_raw, mem_read_raw;
    logic       mem_write_raw, ir_write_raw, mem_to_reg_raw, reg_dst_raw;
    logic       reg_write_raw, alu_src_a_raw, instr_done_raw, illegal_op_raw;
    logic [1:0] alu_src_b_raw, alu_op_raw, pc_source_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        pc_write_raw      = 1'b0;
        pc_write_cond_raw = 1'b0;
        iord_raw          = 1'b0;
        mem_read_raw      = 1'b0;
        mem_write_raw     = 1'b0;
        ir_write_raw      = 1'b0;
        mem_to_reg_raw    = 1'b0;
        reg_dst_raw       = 1'b0;
        reg_write_raw     = 1'b0;
        alu_src_a_raw     = 1'b0;
        alu_src_b_raw     = 2'b00;
        alu_op_raw        = 2'b00;
        pc_source_raw     = 2'b00;
        instr_done_raw    = 1'b0;
        illegal_op_raw    = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC+4 is computed every fetch cycle, but IR/PC only load
                // when the memory actually returns the instruction.
                mem_read_raw  = 1'b1;
                alu_src_b_raw = 2'b01;
                ir_write_raw  = mem_ready;
                pc_write_raw  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut while decoding.
                alu_src_b_raw = 2'b11;
                case (opcode)
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default: begin
                        state_d        = S_FETCH;
                        illegal_op_raw = 1'b1;
                        instr_done_raw = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a_raw = 1'b1;
                alu_src_b_raw = 2'b10;
                state_d       = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read_raw = 1'b1;
                iord_raw     = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write_raw  = 1'b1;
                mem_to_reg_raw = 1'b1;
                instr_done_raw = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write_raw  = 1'b1;
                iord_raw       = 1'b1;
                instr_done_raw = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTE: begin
                alu_src_a_raw = 1'b1;
                alu_op_raw    = 2'b10;
                state_d       = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write_raw  = 1'b1;
                reg_dst_raw    = 1'b1;
                instr_done_raw = 1'b1;
                state_d        = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_raw     = 1'b1;
                alu_op_raw        = 2'b01;
                pc_write_cond_raw = 1'b1;
                pc_source_raw     = 2'b01;
                instr_done_raw    = 1'b1;
                state_d           = S_FETCH;
            end
            S_JUMP: begin
                pc_write_raw   = 1'b1;
                pc_source_raw  = 2'b10;
                instr_done_raw = 1'b1;
                state_d        = S_FETCH;
            end
            S_ADDI_EXEC: begin
                alu_src_a_raw = 1'b1;
                alu_src_b_raw = 2'b10;
                state_d       = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
                state_d        = S_FETCH;
            end
            default: begin
                // Unused encodings: all outputs stay 0, recover to FETCH.
                state_d = S_FETCH;
            end
        endcase
    end

    // Reset masks every output combinationally so an aborted instruction
    // cannot issue a write during the reset cycle.
    assign pc_write      = ~rst & pc_write_raw;
    assign pc_write_cond = ~rst & pc_write_cond_raw;
    assign iord          = ~rst & iord_raw;
    assign mem_read      = ~rst & mem_read_raw;
    assign mem_write     = ~rst & mem_write_raw;
    assign ir_write      = ~rst & ir_write_raw;
    assign mem_to_reg    = ~rst & mem_to_reg_raw;
    assign reg_dst       = ~rst & reg_dst_raw;
    assign reg_write     = ~rst & reg_write_raw;
    assign alu_src_a     = ~rst & alu_src_a_raw;
    assign alu_src_b     = rst ? 2'b00 : alu_src_b_raw;
    assign alu_op        = rst ? 2'b00 : alu_op_raw;
    assign pc_source     = rst ? 2'b00 : pc_source_raw;
    assign state         = rst ? 4'd0 : state_q;
    assign instr_done    = ~rst & instr_done_raw;
    assign illegal_op    = ~rst & illegal_op_raw;

`ifdef INSTR_COUNT_EN
    logic [CNT_WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (instr_done_raw) begin
            count_q <= count_q + CNT_WIDTH'(1);
        end
    end

    assign instr_count = rst ? '0 : count_q;
`else
    assign instr_count = '0;
`endif

endmodule
